// File: rtl/cycle_loader_if.sv
// cycle_loader_if: control handshake, BRAM read port and status of the cycle loader.
interface cycle_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) ();
    logic                  start;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  pending;
    logic                  done;
    logic [ADDR_WIDTH-1:0] clamp_cnt;

    modport master (
        input  start, commit, data,
        output addr, busy, pending, done, clamp_cnt
    );

    modport slave (
        output start, commit, data,
        input  addr, busy, pending, done, clamp_cnt
    );
endinterface

// File: rtl/cycle_loader.sv
// cycle_loader: streams the PWM cycle table from config BRAM into a clamped shadow copy,
// then swaps it into the active CYCLE array in one edge on commit.
module cycle_loader #(
    parameter int WIDTH         = 13,
    parameter int DEPTH         = 249,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int RD_LATENCY    = 2,
    parameter int DEFAULT_CYCLE = 4096,
    parameter int MIN_CYCLE     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cycle_loader_if.master              bus,
    output logic [DEPTH-1:0][WIDTH-1:0] cycle_o
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT} state_t;

    state_t                                state_q, state_d;
    logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]                 clamp_cnt_q, clamp_cnt_d;
    logic [RD_LATENCY-1:0]                 vld_q;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] idx_q;
    logic [DEPTH-1:0][WIDTH-1:0]           shadow_q, cycle_q;
    logic                                  done_q;
    logic                                  start_ok, commit_ok, last_addr;
    logic                                  over, under, clamped;
    logic [WIDTH-1:0]                      din_c;

    assign start_ok  = (state_q == IDLE) && bus.start;
    assign commit_ok = (state_q == WAIT) && bus.commit;
    assign last_addr = addr_q == ADDR_WIDTH'(DEPTH - 1);
    assign over      = |bus.data[DATA_WIDTH-1:WIDTH];
    assign under     = bus.data[WIDTH-1:0] < WIDTH'(MIN_CYCLE);
    assign clamped   = vld_q[RD_LATENCY-1] && (over || under);
    assign din_c     = over ? '1 : under ? WIDTH'(MIN_CYCLE) : bus.data[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // DRAIN ends once the delayed-valid pipe has emptied, i.e. one cycle after the last capture
    always_comb begin
        state_d = start_ok                                   ? READ  :
                  (state_q == READ && last_addr)             ? DRAIN :
                  (state_q == DRAIN && vld_q == '0)          ? WAIT  :
                  commit_ok                                  ? IDLE  : state_q;
        addr_d      = (state_q == READ && state_d == READ) ? addr_q + 1'b1 :
                      (state_d == IDLE)                    ? '0 : addr_q;
        clamp_cnt_d = start_ok ? '0 : clamp_cnt_q + ADDR_WIDTH'(clamped);
    end

    always_comb begin
        bus.addr      = addr_q;
        bus.busy      = state_q != IDLE;
        bus.pending   = state_q == WAIT;
        bus.done      = done_q;
        bus.clamp_cnt = clamp_cnt_q;
        cycle_o       = cycle_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            clamp_cnt_q <= '0;
            vld_q       <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            cycle_q     <= {DEPTH{WIDTH'(DEFAULT_CYCLE)}};
        end else begin
            addr_q      <= addr_d;
            clamp_cnt_q <= clamp_cnt_d;
            vld_q[0]    <= state_q == READ;
            idx_q[0]    <= addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
            done_q <= commit_ok;
            if (commit_ok) cycle_q <= shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_q[RD_LATENCY-1]) shadow_q[idx_q[RD_LATENCY-1]] <= din_c;
    end
endmodule
